uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 73 +++++++
 tb/tb_uart_tx_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO feeding a start/done serializer handshake, with a SendDone watchdog.
module uart_tx_buffer #(
  parameter int Depth         = 16,
  parameter int AddrWidth     = 4,
  parameter int TimeoutCycles = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WrEn,
  input  logic [7:0]           WrData,
  input  logic                 Flush,
  input  logic                 SendBusy,
  input  logic                 SendDone,
  output logic                 SendEn,
  output logic [7:0]           SendData,
  output logic                 Full,
  output logic                 Empty,
  output logic [AddrWidth:0]   Count,
  output logic                 Overflow,
  output logic                 TxErr
);
  localparam int WdWidth = $clog2(TimeoutCycles) > 20 ? $clog2(TimeoutCycles) : 20;
  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t               state;
  logic [7:0]           mem [Depth];
  logic [AddrWidth-1:0] wr_ptr, rd_ptr;
  logic [WdWidth-1:0]   wd;
  logic                 push, pop;
  assign Full  = Count == (AddrWidth+1)'(Depth);
  assign Empty = Count == '0;
  // Full is taken from the registered count, so a write while full is dropped even if a pop happens now
  assign push  = WrEn && !Full && !Flush;
  assign pop   = state == IDLE && !Empty && !SendBusy && !Flush;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= WrData;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      wd       <= '0;
      SendEn   <= 1'b0;
      SendData <= 8'h00;
      Overflow <= 1'b0;
      TxErr    <= 1'b0;
    end else begin
      SendEn   <= pop;
      Overflow <= WrEn && Full && !Flush;
      TxErr    <= 1'b0;
      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        Count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        Count <= Count + (AddrWidth+1)'(push) - (AddrWidth+1)'(pop);
      end
      if (pop) SendData <= mem[rd_ptr];
      // Flush leaves an in-flight byte alone; only SendDone or the watchdog end the wait
      if (state == IDLE) begin
        if (pop) begin
          state <= WAIT_DONE;
          wd    <= '0;
        end
      end else if (SendDone) state <= IDLE;
      else if (wd == WdWidth'(TimeoutCycles - 1)) begin
        state <= IDLE;
        TxErr <= 1'b1;
      end else wd <= wd + 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed checks of queueing, handshake timing, overflow, timeout, flush and reset.
module tb_uart_tx_buffer;
  logic       clk = 0, rst = 1, WrEn = 0, Flush = 0, SendDone = 0;
  logic [7:0] WrData = 0;
  logic       hold_busy = 0, ser_busy = 0, ser_auto = 1, SendBusy;
  logic       SendEn, Full, Empty, Overflow, TxErr;
  logic [7:0] SendData;
  logic [4:0] Count;
  int         checks = 0, errors = 0, cyc = 0, bt = 0, done_edge = 0, txerr_n = 0, txerr_cyc = 0;
  logic [7:0] snd[$];
  int         snd_cyc[$], gap[$];
  assign SendBusy = hold_busy | ser_busy;
  uart_tx_buffer dut (.clk(clk), .rst(rst), .WrEn(WrEn), .WrData(WrData), .Flush(Flush),
    .SendBusy(SendBusy), .SendDone(SendDone), .SendEn(SendEn), .SendData(SendData),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow), .TxErr(TxErr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // serializer model: busy for 10 bit-times after SendEn, then a one-cycle SendDone
  always @(negedge clk) begin
    SendDone = 0;
    if (SendEn) begin
      snd.push_back(SendData);
      snd_cyc.push_back(cyc);
      gap.push_back(cyc - done_edge);
      if (ser_auto) begin
        ser_busy = 1;
        bt = 10;
      end
    end else if (bt > 0) begin
      bt--;
      if (bt == 0) begin
        ser_busy = 0;
        SendDone = 1;
        done_edge = cyc + 1;
      end
    end
    if (TxErr) begin
      txerr_n++;
      txerr_cyc = cyc;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic wait_sends(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && snd.size() < n; i++) @(negedge clk);
    check(tag, snd.size(), n);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_senden"}, SendEn, 0);
    check({tag, "_senddata"}, SendData, 8'h00);
    check({tag, "_full"}, Full, 0);
    check({tag, "_empty"}, Empty, 1);
    check({tag, "_count"}, Count, 0);
    check({tag, "_overflow"}, Overflow, 0);
    check({tag, "_txerr"}, TxErr, 0);
  endtask
  initial begin
    int base;
    cycles(2);
    #1 check_reset("rst");
    @(negedge clk) rst = 0;
    cycles(2);
    // single byte: Count=1 after the write edge, SendEn with data one edge later
    WrEn = 1; WrData = 8'hA5;
    @(negedge clk) WrEn = 0;
    check("single_count1", Count, 1);
    check("single_noen", SendEn, 0);
    @(negedge clk);
    check("single_en", SendEn, 1);
    check("single_data", SendData, 8'hA5);
    check("single_count0", Count, 0);
    @(negedge clk);
    check("single_pulse", SendEn, 0);
    check("single_hold", SendData, 8'hA5);
    cycles(15);
    check("single_sends", snd.size(), 1);
    // burst of 16 bytes through the serializer model
    base = snd.size();
    for (int i = 1; i <= 16; i++) begin
      WrEn = 1; WrData = 8'(i);
      @(negedge clk);
    end
    WrEn = 0;
    wait_sends("burst_sends", base + 16, 400);
    for (int i = 0; i < 16; i++) begin
      if (base + i < snd.size()) begin
        check($sformatf("burst_data%0d", i), snd[base+i], i + 1);
        if (i > 0) check($sformatf("burst_gap%0d", i), gap[base+i], 1);
      end
    end
    cycles(15);
    // overflow with the serializer held busy
    hold_busy = 1;
    base = snd.size();
    for (int i = 0; i < 16; i++) begin
      WrEn = 1; WrData = 8'h20 + 8'(i);
      @(negedge clk);
    end
    check("ovf_full", Full, 1);
    check("ovf_count16", Count, 16);
    check("ovf_none_yet", Overflow, 0);
    WrData = 8'hEE;
    @(negedge clk) WrEn = 0;
    check("ovf_pulse", Overflow, 1);
    check("ovf_count_stay", Count, 16);
    @(negedge clk);
    check("ovf_pulse_end", Overflow, 0);
    hold_busy = 0;
    wait_sends("ovf_drain", base + 16, 400);
    cycles(30);
    check("ovf_drain_exact", snd.size(), base + 16);
    check("ovf_first", snd[base], 8'h20);
    check("ovf_last", snd[snd.size()-1], 8'h2F);
    check("ovf_empty", Empty, 1);
    // timeout: no SendDone for the first byte, second byte goes out after TxErr
    ser_auto = 0;
    base = snd.size();
    WrEn = 1; WrData = 8'h5A;
    @(negedge clk) WrData = 8'h6B;
    @(negedge clk) WrEn = 0;
    for (int i = 0; i < 5100 && txerr_n == 0; i++) @(negedge clk);
    ser_auto = 1;
    check("to_seen", txerr_n, 1);
    check("to_delay", txerr_cyc - snd_cyc[base], 5000);
    wait_sends("to_next", base + 2, 10);
    check("to_next_data", snd[snd.size()-1], 8'h6B);
    check("to_single_pulse", txerr_n, 1);
    cycles(20);
    // flush while a byte is in flight with 5 queued
    base = snd.size();
    for (int i = 0; i < 6; i++) begin
      WrEn = 1; WrData = 8'h40 + 8'(i);
      @(negedge clk);
    end
    WrEn = 0;
    check("fl_count5", Count, 5);
    Flush = 1; WrEn = 1; WrData = 8'h99;
    @(negedge clk) begin Flush = 0; WrEn = 0; end
    check("fl_count0", Count, 0);
    check("fl_empty", Empty, 1);
    check("fl_no_ovf", Overflow, 0);
    cycles(30);
    check("fl_sends", snd.size(), base + 1);
    // reset with one byte in flight and 3 queued
    base = snd.size();
    for (int i = 0; i < 4; i++) begin
      WrEn = 1; WrData = 8'h60 + 8'(i);
      @(negedge clk);
    end
    WrEn = 0;
    check("rm_count3", Count, 3);
    rst = 1;
    #1 check_reset("rm");
    cycles(2);
    rst = 0;
    cycles(30);
    check("rm_no_send", snd.size(), base + 1);
    WrEn = 1; WrData = 8'h77;
    @(negedge clk) WrEn = 0;
    wait_sends("rm_new", base + 2, 10);
    check("rm_new_data", snd[snd.size()-1], 8'h77);
    cycles(15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
